// File: rtl/fp_compare_pipe_if.sv
// fp_compare_pipe_if: handshake and operand/result bundle for fp_compare_pipe.
// out_minmax exists only when FP_CMP_MINMAX_EN is defined.
interface fp_compare_pipe_if #(
  parameter int W     = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [3:0]       cmp_type;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             out_y;
  logic             out_unord;
  logic             out_invalid;
`ifdef FP_CMP_MINMAX_EN
  logic [W-1:0]     out_minmax;

  modport master (
    output in_valid, in_tag, a, b, cmp_type, out_ready,
    input  in_ready, out_valid, out_tag, out_y, out_unord, out_invalid, out_minmax
  );
  modport slave (
    input  in_valid, in_tag, a, b, cmp_type, out_ready,
    output in_ready, out_valid, out_tag, out_y, out_unord, out_invalid, out_minmax
  );
`else
  modport master (
    output in_valid, in_tag, a, b, cmp_type, out_ready,
    input  in_ready, out_valid, out_tag, out_y, out_unord, out_invalid
  );
  modport slave (
    input  in_valid, in_tag, a, b, cmp_type, out_ready,
    output in_ready, out_valid, out_tag, out_y, out_unord, out_invalid
  );
`endif
endinterface

// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: pipelined IEEE-754 compare with valid/ready backpressure and tag.
// The predicate is evaluated as an operation enters stage 0; later stages only
// carry it. Stalls collapse bubbles. Define FP_CMP_MINMAX_EN to add MIN/MAX.
module fp_compare_pipe #(
  parameter int W     = 32,
  parameter int D     = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  fp_compare_pipe_if.slave bus
);
  localparam int F = (W == 64) ? 52 : 23;
  localparam int E = (W == 64) ? 11 : 8;

  localparam logic [3:0] CMP_LT  = 4'd1;
  localparam logic [3:0] CMP_LE  = 4'd2;
  localparam logic [3:0] CMP_EQ  = 4'd3;
  localparam logic [3:0] CMP_UN  = 4'd4;
  localparam logic [3:0] CMP_ULT = 4'd5;
  localparam logic [3:0] CMP_ULE = 4'd6;
  localparam logic [3:0] CMP_UEQ = 4'd7;
  localparam logic [3:0] CMP_MIN = 4'd8;
  localparam logic [3:0] CMP_MAX = 4'd9;

  logic a_nan, b_nan, a_snan, b_snan, unord_c, both_zero;
  logic lt_raw, lt_c, eq_c, y_c, inv_c;

  logic [D-1:0]     v_q, v_d, rdy;
  logic [D-1:0]     y_q, y_d, unord_q, unord_d, inv_q, inv_d;
  logic [TAG_W-1:0] tag_q [D];
  logic [TAG_W-1:0] tag_d [D];

  // Classify operands and evaluate the selected predicate and invalid flag.
  always_comb begin
    a_nan     = (&bus.a[W-2 -: E]) && (|bus.a[F-1:0]);
    b_nan     = (&bus.b[W-2 -: E]) && (|bus.b[F-1:0]);
    a_snan    = a_nan && !bus.a[F-1];
    b_snan    = b_nan && !bus.b[F-1];
    unord_c   = a_nan || b_nan;
    both_zero = !(|bus.a[W-2:0]) && !(|bus.b[W-2:0]);
    // Sign first; equal signs compare magnitudes, reversed when both negative.
    // -0 < +0 here; the ordered predicates mask that with both_zero.
    if (bus.a[W-1] != bus.b[W-1])
      lt_raw = bus.a[W-1];
    else if (bus.a[W-1])
      lt_raw = bus.a[W-2:0] > bus.b[W-2:0];
    else
      lt_raw = bus.a[W-2:0] < bus.b[W-2:0];
    lt_c = !unord_c && !both_zero && lt_raw;
    eq_c = !unord_c && ((bus.a == bus.b) || both_zero);
    y_c   = 1'b0;
    inv_c = 1'b0;
    case (bus.cmp_type)
      CMP_LT:  begin y_c = lt_c;                    inv_c = unord_c; end
      CMP_LE:  begin y_c = lt_c || eq_c;            inv_c = unord_c; end
      CMP_EQ:  begin y_c = eq_c;                    inv_c = a_snan || b_snan; end
      CMP_UN:  begin y_c = unord_c;                 inv_c = a_snan || b_snan; end
      CMP_ULT: begin y_c = unord_c || lt_c;         inv_c = a_snan || b_snan; end
      CMP_ULE: begin y_c = unord_c || lt_c || eq_c; inv_c = a_snan || b_snan; end
      CMP_UEQ: begin y_c = unord_c || eq_c;         inv_c = a_snan || b_snan; end
`ifdef FP_CMP_MINMAX_EN
      CMP_MIN, CMP_MAX: inv_c = a_snan || b_snan;
`endif
      default: ;
    endcase
  end

`ifdef FP_CMP_MINMAX_EN
  logic [W-1:0] mm_c, qnan_c;
  logic [W-1:0] mm_q [D];
  logic [W-1:0] mm_d [D];

  // Min/max selection; a lone NaN yields the other operand, two NaNs the canonical qNaN.
  always_comb begin
    qnan_c = '0;
    qnan_c[W-2:F-1] = '1;
    mm_c = '0;
    if (bus.cmp_type == CMP_MIN || bus.cmp_type == CMP_MAX) begin
      if (a_nan && b_nan)
        mm_c = qnan_c;
      else if (a_nan)
        mm_c = bus.b;
      else if (b_nan)
        mm_c = bus.a;
      else if (bus.cmp_type == CMP_MIN)
        mm_c = lt_raw ? bus.a : bus.b;
      else
        mm_c = lt_raw ? bus.b : bus.a;
    end
  end
`endif

  // Per-stage ready: a stage may load when empty or when the stage ahead can move.
  always_comb begin
    logic r;
    r = !v_q[D-1] || bus.out_ready;
    rdy[D-1] = r;
    for (int i = D-2; i >= 0; i--) begin
      r = !v_q[i] || r;
      rdy[i] = r;
    end
  end

  // Advance every ready stage from its predecessor; stage 0 loads from the input.
  always_comb begin
    v_d     = v_q;
    y_d     = y_q;
    unord_d = unord_q;
    inv_d   = inv_q;
    tag_d   = tag_q;
`ifdef FP_CMP_MINMAX_EN
    mm_d    = mm_q;
`endif
    if (rdy[0]) begin
      v_d[0]     = bus.in_valid;
      y_d[0]     = y_c;
      unord_d[0] = unord_c;
      inv_d[0]   = inv_c;
      tag_d[0]   = bus.in_tag;
`ifdef FP_CMP_MINMAX_EN
      mm_d[0]    = mm_c;
`endif
    end
    for (int i = 1; i < D; i++) begin
      if (rdy[i]) begin
        v_d[i]     = v_q[i-1];
        y_d[i]     = y_q[i-1];
        unord_d[i] = unord_q[i-1];
        inv_d[i]   = inv_q[i-1];
        tag_d[i]   = tag_q[i-1];
`ifdef FP_CMP_MINMAX_EN
        mm_d[i]    = mm_q[i-1];
`endif
      end
    end
  end

  // Pipeline registers; reset drops in-flight work and zeroes the result path.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      y_q     <= '0;
      unord_q <= '0;
      inv_q   <= '0;
      for (int i = 0; i < D; i++) begin
        tag_q[i] <= '0;
`ifdef FP_CMP_MINMAX_EN
        mm_q[i]  <= '0;
`endif
      end
    end else begin
      v_q     <= v_d;
      y_q     <= y_d;
      unord_q <= unord_d;
      inv_q   <= inv_d;
      tag_q   <= tag_d;
`ifdef FP_CMP_MINMAX_EN
      mm_q    <= mm_d;
`endif
    end
  end

  assign bus.in_ready    = rdy[0];
  assign bus.out_valid   = v_q[D-1];
  assign bus.out_tag     = tag_q[D-1];
  assign bus.out_y       = y_q[D-1];
  assign bus.out_unord   = unord_q[D-1];
  assign bus.out_invalid = inv_q[D-1];
`ifdef FP_CMP_MINMAX_EN
  assign bus.out_minmax  = mm_q[D-1];
`endif
endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: directed vectors with a scoreboard queue; a negedge
// monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_fp_compare_pipe;
  localparam int W = 32;
  localparam int D = 4;
  localparam int TAG_W = 8;

  localparam logic [3:0] T_NONE = 4'd0, T_LT = 4'd1, T_LE = 4'd2, T_EQ = 4'd3,
                         T_UN = 4'd4, T_ULT = 4'd5, T_ULE = 4'd6, T_UEQ = 4'd7,
                         T_MIN = 4'd8, T_MAX = 4'd9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_compare_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();
  fp_compare_pipe #(.W(W), .D(D), .TAG_W(TAG_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             y;
    logic             unord;
    logic             inv;
    logic             chk_mm;
    logic [W-1:0]     mm;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present one op; push its expected result once it is seen accepted.
  task automatic send(input logic [TAG_W-1:0] tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] ct, input logic ey, input logic eu, input logic ei,
                      input logic cmm = 1'b0, input logic [W-1:0] emm = '0);
    int n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_tag   = tag;
    bus.a        = a;
    bus.b        = b;
    bus.cmp_type = ct;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout tag=%0h actual in_ready=0 required 1", tag);
    end else begin
      e.tag = tag; e.y = ey; e.unord = eu; e.inv = ei; e.chk_mm = cmm; e.mm = emm;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each transferred result against the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual tag=%0h required no result", bus.out_tag);
      end else begin
        e = sb_q.pop_front();
        chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
        chk("out_y", 64'(bus.out_y), 64'(e.y));
        chk("out_unord", 64'(bus.out_unord), 64'(e.unord));
        chk("out_invalid", 64'(bus.out_invalid), 64'(e.inv));
`ifdef FP_CMP_MINMAX_EN
        if (e.chk_mm) chk("out_minmax", 64'(bus.out_minmax), 64'(e.mm));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_tag = '0;
    bus.a = '0;
    bus.b = '0;
    bus.cmp_type = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_y", 64'(bus.out_y), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Latency: first op presented in cycle 0, out_valid seen 4 cycles later.
    send(8'd5, 32'hBF800000, 32'h3F800000, T_LT, 1, 0, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 20);
    chk("latency", 64'(k), 64'(D));
    drain();

    // Directed predicates, back to back.
    send(8'd1,  32'h80000000, 32'h00000000, T_EQ,   1, 0, 0);
    send(8'd2,  32'h7FC00000, 32'h3F800000, T_LE,   0, 1, 1);
    send(8'd3,  32'h7FC00000, 32'h3F800000, T_UEQ,  1, 1, 0);
    send(8'd4,  32'h7F800001, 32'h00000000, T_EQ,   0, 1, 1);
    send(8'd6,  32'hC0000000, 32'hBF800000, T_LT,   1, 0, 0);
    send(8'd7,  32'hBF800000, 32'hC0000000, T_LT,   0, 0, 0);
    send(8'd8,  32'h3F800000, 32'h3F800000, T_LE,   1, 0, 0);
    send(8'd9,  32'h3F800000, 32'h7F800001, T_UN,   1, 1, 1);
    send(8'd10, 32'h7FC00000, 32'h00000000, T_ULT,  1, 1, 0);
    send(8'h20, 32'h3F800000, 32'h40000000, T_ULE,  1, 0, 0);
    send(8'h21, 32'h7F800001, 32'h00000000, T_NONE, 0, 1, 0);
    send(8'h22, 32'h7FC00000, 32'h00000000, 4'd12,  0, 1, 0);
    send(8'h23, 32'h00000001, 32'h00000002, T_LT,   1, 0, 0);
    send(8'h24, 32'h80000002, 32'h80000001, T_LT,   1, 0, 0);
    send(8'h25, 32'h00000000, 32'h80000000, T_LT,   0, 0, 0);
    send(8'h26, 32'h80000000, 32'h00000000, T_LE,   1, 0, 0);
    send(8'h27, 32'h7F800000, 32'h7F7FFFFF, T_LT,   0, 0, 0);
    send(8'h28, 32'h7FC00000, 32'h7FC00000, T_LT,   0, 1, 1);
`ifdef FP_CMP_MINMAX_EN
    send(8'h30, 32'h00000000, 32'h80000000, T_MIN, 0, 0, 0, 1, 32'h80000000);
    send(8'h31, 32'h7FC00000, 32'h40000000, T_MAX, 0, 1, 0, 1, 32'h40000000);
    send(8'h32, 32'h7FC00000, 32'h7FC00001, T_MIN, 0, 1, 0, 1, 32'h7FC00000);
    send(8'h33, 32'h7F800001, 32'h3F800000, T_MAX, 0, 1, 1, 1, 32'h3F800000);
    send(8'h34, 32'h3F800000, 32'hBF800000, T_MIN, 0, 0, 0, 1, 32'hBF800000);
    send(8'h35, 32'h80000000, 32'h00000000, T_MAX, 0, 0, 0, 1, 32'h00000000);
`else
    send(8'h30, 32'h7F800001, 32'h00000000, T_MIN, 0, 1, 0);
    send(8'h31, 32'h3F800000, 32'h40000000, T_MAX, 0, 0, 0);
`endif
    drain();

    // Backpressure: four accepts fill the pipe, outputs hold, then release.
    bus.out_ready = 1'b0;
    send(8'd11, 32'hBF800000, 32'h3F800000, T_LT, 1, 0, 0);
    send(8'd12, 32'h3F800000, 32'hBF800000, T_LT, 0, 0, 0);
    send(8'd13, 32'h3F800000, 32'h3F800000, T_EQ, 1, 0, 0);
    send(8'd14, 32'h7FC00000, 32'h00000000, T_UN, 1, 1, 0);
    @(negedge clk);
    chk("in_ready_full", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_tag", 64'(bus.out_tag), 64'd11);
      chk("stall_y", 64'(bus.out_y), 64'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    fork
      begin
        send(8'd15, 32'h40000000, 32'h3F800000, T_LE,  0, 0, 0);
        send(8'd16, 32'h00000000, 32'h80000000, T_ULE, 1, 0, 0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight; in_valid during reset must be ignored.
    bus.out_ready = 1'b0;
    send(8'd21, 32'hBF800000, 32'h3F800000, T_LT, 1, 0, 0);
    send(8'd22, 32'h7F800001, 32'h00000000, T_EQ, 0, 1, 1);
    send(8'd23, 32'h3F800000, 32'h3F800000, T_LE, 1, 0, 0);
    reset = 1'b1;
    sb_q.delete();
    bus.in_valid = 1'b1;
    bus.in_tag = 8'd99;
    bus.a = 32'h7F800001;
    bus.b = 32'h00000000;
    bus.cmp_type = T_LT;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_out_y", 64'(bus.out_y), 64'd0);
    chk("rst2_out_unord", 64'(bus.out_unord), 64'd0);
    chk("rst2_out_invalid", 64'(bus.out_invalid), 64'd0);
    chk("rst2_out_tag", 64'(bus.out_tag), 64'd0);
`ifdef FP_CMP_MINMAX_EN
    chk("rst2_out_minmax", 64'(bus.out_minmax), 64'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst2_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(8'd40, 32'hC0000000, 32'hBF800000, T_LE, 1, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_compare_pipe.md
# fp_compare_pipe

Pipelined, parametrised IEEE-754 compare unit for the FPU. Compared with the fixed-depth shift-register compare it has a valid/ready handshake with backpressure and a tag carried alongside each operation. It adds unordered/NaN-aware predicates and an invalid-operation flag. It sits between the FP issue queue and the FCSR/condition-code writeback, and accepts one compare per cycle.

## Interface
Parameters:
- `W`, default 32: operand width, 32 or 64 (F=23/E=8 or F=52/E=11).
- `D`, default 4: pipeline stages, legal range 1..8.
- `TAG_W`, default 8: width of the opaque tag (ROB pointer).

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: synchronous reset, active-high.
- `in_valid`  in  1: an operation is presented.
- `in_ready`  out  1: the unit accepts this cycle.
- `in_tag`  in  TAG_W: tag for the operation.
- `a`, `b`  in  W: operands.
- `cmp_type`  in  4: predicate select.
- `out_valid`  out  1: a result is presented.
- `out_ready`  in  1: the consumer accepts this cycle.
- `out_tag`  out  TAG_W: tag of the result.
- `out_y`  out  1: predicate result.
- `out_unord`  out  1: at least one operand is NaN.
- `out_invalid`  out  1: IEEE invalid-operation flag.
- `out_minmax`  out  W: min/max result, present only with `FP_CMP_MINMAX_EN`.

## Operation
- Classification:
  - NaN: exponent all ones and mantissa ≠ 0.
  - sNaN: NaN with mantissa MSB = 0.
  - ±0 compare equal.
  - Denormals are compared exactly, with no flushing.
- Ordering: sign-magnitude compare (sign, then exponent, then mantissa). If both operands are negative, the magnitude sense is reversed.
- `cmp_type`:
  - 0 `NONE`: y=0.
  - 1 `LT`.
  - 2 `LE`.
  - 3 `EQ`.
  - 4 `UN`: y=unord.
  - 5 `ULT`: unord|lt.
  - 6 `ULE`: unord|le.
  - 7 `UEQ`: unord|eq.
  - 8 `MIN`, 9 `MAX`: y=0; the result is on `out_minmax`.
  - 10..15: y=0, invalid=0.
- Ordered predicates (1,2,3) give y=0 when unord=1.
- `out_invalid` rules:
  - `LT`/`LE`: set by any NaN operand (signalling compare).
  - `EQ`/`UN`/`ULT`/`ULE`/`UEQ`/`MIN`/`MAX`: set only by an sNaN operand.
  - `NONE`: always 0.
- Evaluation happens in the cycle the operation enters stage 0. Later stages only carry the result, tag and flags.

## Timing
- Latency: D cycles from the accept edge to `out_valid`=1, when `out_ready` stays high.
- Throughput: 1 operation per cycle.
- Stage valid bits `v[0..D-1]`:
  - `rdy[D-1] = !v[D-1] | out_ready`.
  - `rdy[i] = !v[i] | rdy[i+1]`.
  - `in_ready = rdy[0]`, combinational from `out_ready` (no skid buffer).
- Transfers:
  - Input transfer: `in_valid & in_ready`.
  - Output transfer: `out_valid & out_ready`.
  - `out_valid = v[D-1]`.
- While `out_valid=1` and `out_ready=0`, `out_*` hold stable. Full pipeline: `in_ready=0`.
- Bubbles collapse: a stalled output does not block stages that have an empty stage ahead of them.
- Simultaneous output transfer and input transfer on a full pipeline: both occur, with no loss.
- Reset (synchronous):
  - Clears all `v`, so `out_valid=0` on the following cycle.
  - Zeroes `out_y`, `out_unord`, `out_invalid`, `out_tag` and `out_minmax`.
  - `in_ready=1` once reset deasserts.
  - In-flight operations are discarded.
  - `in_valid` during reset is ignored.
- Ordering: results leave in acceptance order.

## Configuration
- Macro: `FP_CMP_MINMAX_EN`.
- Defined:
  - `MIN`/`MAX` return the lesser/greater operand.
  - -0 is treated as less than +0.
  - If exactly one operand is NaN, the other operand is returned.
  - If both are NaN, the canonical qNaN is returned (W=32 `0x7FC00000`; W=64 `0x7FF8000000000000`).
  - Invalid is set on an sNaN operand.
- Undefined:
  - The `out_minmax` port and its datapath are absent.
  - Types 8/9 behave like 10..15 (y=0, invalid=0).

## Test plan
- W=32, D=4, `out_ready`=1, `LT` a=`0xBF800000` (-1.0) b=`0x3F800000` (1.0), tag 5 → 4 cycles later `out_valid`=1, y=1, invalid=0, `out_tag`=5.
- `EQ` a=`0x80000000` b=`0x00000000` → y=1; `LE` a=`0x7FC00000` b=`0x3F800000` → y=0, unord=1, invalid=1; `UEQ` with the same operands → y=1, invalid=0.
- `EQ` a=`0x7F800001` (sNaN) b=0 → y=0, invalid=1; `LT` with both operands negative, a=-2.0 b=-1.0 → y=1.
- Backpressure: 6 back-to-back ops with `out_ready`=0 → `in_ready` falls after 4 accepts; raise `out_ready` → all 6 results emerge in order, tags intact, outputs stable while stalled.
- Reset asserted with 3 ops in flight → `out_valid`=0 the next cycle, all outputs 0, `in_ready`=1, no stale result appears afterwards.
- With `FP_CMP_MINMAX_EN`, W=64: `MIN` of +0/-0 → `0x8000000000000000`; `MAX` of qNaN/2.0 → `0x4000000000000000`; `MIN` of two qNaNs → `0x7FF8000000000000`.
